// File: rtl/barrel_shifter_pipe_if.sv
// barrel_shifter_pipe_if: valid/ready operand and result channels of the pipelined barrel shifter
interface barrel_shifter_pipe_if #(parameter int WIDTH = 8);
   localparam int SW = $clog2(WIDTH);
   logic in_valid, in_ready, out_valid, out_ready, out_zero;
   logic [WIDTH-1:0] data_in, data_out;
   logic [SW-1:0] shift_amt;
   logic [2:0] mode;
   modport master (output in_valid, data_in, shift_amt, mode, out_ready,
                   input in_ready, out_valid, data_out, out_zero);
   modport slave (input in_valid, data_in, shift_amt, mode, out_ready,
                  output in_ready, out_valid, data_out, out_zero);
endinterface

// File: rtl/barrel_shifter_pipe.sv
// barrel_shifter_pipe: log2(WIDTH)-stage shifter; stage k shifts by 2^k when shift_amt[k] is set
module barrel_shifter_pipe #(parameter int WIDTH = 8) (
   input logic clk,
   input logic rst,
   barrel_shifter_pipe_if.slave bus
);
   localparam int SW = $clog2(WIDTH);
   logic en, z;
   logic [SW-1:0] v, si_v;
   logic [WIDTH-1:0] d [SW], si_d [SW], nx [SW];
   logic [SW-1:0] a [SW], si_a [SW];
   logic [2:0] m [SW], si_m [SW];
   logic f [SW], si_f [SW];
   function automatic logic [WIDTH-1:0] step(input logic [WIDTH-1:0] x, input logic [2:0] md,
                                             input logic fill, input logic on, input int s);
      return !on ? x :
             md == 3'd0 ? x << s :
             md == 3'd1 ? x >> s :
             md == 3'd2 ? (x >> s) | ({WIDTH{fill}} << (WIDTH - s)) :
             md == 3'd3 ? (x << s) | (x >> (WIDTH - s)) :
             md == 3'd4 ? (x >> s) | (x << (WIDTH - s)) : x;
   endfunction
   assign en = !v[SW-1] || bus.out_ready;
   assign bus.in_ready = en;
   assign bus.out_valid = v[SW-1];
   assign bus.data_out = d[SW-1];
   assign bus.out_zero = z;
   // The SRA fill bit is the operand's original MSB, captured at entry and carried with the beat
   always_comb begin
      si_v = {v[SW-2:0], bus.in_valid};
      si_d[0] = bus.data_in;
      si_a[0] = bus.shift_amt;
      si_m[0] = bus.mode;
      si_f[0] = bus.data_in[WIDTH-1];
      for (int k = 1; k < SW; k++) begin
         si_d[k] = d[k-1];
         si_a[k] = a[k-1];
         si_m[k] = m[k-1];
         si_f[k] = f[k-1];
      end
      for (int k = 0; k < SW; k++) nx[k] = step(si_d[k], si_m[k], si_f[k], si_a[k][k], 1 << k);
   end
   always_ff @(posedge clk)
      if (rst) begin
         v <= '0;
         d[SW-1] <= '0;
         z <= 1'b0;
      end else if (en) begin
         v <= si_v;
         z <= si_v[SW-1] && nx[SW-1] == '0;
         for (int k = 0; k < SW; k++) begin
            d[k] <= nx[k];
            a[k] <= si_a[k];
            m[k] <= si_m[k];
            f[k] <= si_f[k];
         end
      end
endmodule

// File: tb/tb_barrel_shifter_pipe.sv
// tb_barrel_shifter_pipe: directed vectors on WIDTH=8 plus random valid/ready scoreboards on WIDTH=8 and 32
module tb_barrel_shifter_pipe;
   logic clk = 1'b0, rst = 1'b1;
   int checks = 0, failures = 0;
   always #5 clk = ~clk;
   barrel_shifter_pipe_if #(.WIDTH(8)) b8 ();
   barrel_shifter_pipe_if #(.WIDTH(32)) b32 ();
   barrel_shifter_pipe #(.WIDTH(8)) dut8 (.clk(clk), .rst(rst), .bus(b8));
   barrel_shifter_pipe #(.WIDTH(32)) dut32 (.clk(clk), .rst(rst), .bus(b32));

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [63:0] ref_op(input logic [63:0] x, input int a, input logic [2:0] md, input int w);
      logic [63:0] mask, y;
      mask = (64'd1 << w) - 64'd1;
      y = x & mask;
      case (md)
         3'd0: return (y << a) & mask;
         3'd1: return y >> a;
         3'd2: return (y >> a) | (y[w-1] ? mask & ~(mask >> a) : 64'd0);
         3'd3: return ((y << a) | (y >> (w - a))) & mask;
         3'd4: return ((y >> a) | (y << (w - a))) & mask;
         default: return y;
      endcase
   endfunction

   task automatic drive8(input logic [7:0] x, input logic [2:0] a, input logic [2:0] md);
      b8.in_valid = 1'b1;
      b8.data_in = x;
      b8.shift_amt = a;
      b8.mode = md;
   endtask

   task automatic send1(input string tag, input logic [7:0] x, input logic [2:0] a, input logic [2:0] md, input logic [7:0] e);
      int lat = 0;
      @(negedge clk);
      b8.out_ready = 1'b1;
      drive8(x, a, md);
      for (int c = 1; c <= 8 && lat == 0; c++) begin
         @(negedge clk);
         b8.in_valid = 1'b0;
         if (b8.out_valid) lat = c;
      end
      chk({tag, "_lat"}, lat, 3);
      chk({tag, "_data"}, b8.data_out, e);
      chk({tag, "_zero"}, b8.out_zero, e == 8'h00);
   endtask

   task automatic stream5();
      logic [7:0] x [5] = '{8'h0F, 8'hF0, 8'h81, 8'h81, 8'h12};
      logic [2:0] a [5] = '{3'd1, 3'd4, 3'd1, 3'd1, 3'd4};
      logic [2:0] md [5] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4};
      logic [7:0] e [5] = '{8'h1E, 8'h0F, 8'hC0, 8'h03, 8'h21};
      int got = 0, first = 0, last = 0;
      b8.out_ready = 1'b1;
      for (int c = 0; c < 16; c++) begin
         @(negedge clk);
         if (c < 5) drive8(x[c], a[c], md[c]);
         else b8.in_valid = 1'b0;
         #1;
         if (b8.out_valid) begin
            if (got < 5) chk("stream_data", b8.data_out, e[got]);
            if (got == 0) first = c;
            last = c;
            got++;
         end
      end
      chk("stream_count", got, 5);
      chk("stream_lat", first, 3);
      chk("stream_span", last - first, 4);
   endtask

   task automatic backpressure();
      logic [7:0] x [3] = '{8'h11, 8'h88, 8'hC3};
      logic [2:0] a [3] = '{3'd2, 3'd3, 3'd2};
      logic [2:0] md [3] = '{3'd0, 3'd1, 3'd3};
      logic [7:0] e [4] = '{8'h44, 8'h11, 8'h0F, 8'h01};
      int got = 0, extra = 0;
      logic sent = 1'b0;
      b8.out_ready = 1'b0;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         drive8(x[c], a[c], md[c]);
         #1 chk("bp_fill_ready", b8.in_ready, 1);
      end
      @(negedge clk);
      drive8(8'h40, 3'd6, 3'd2);
      for (int c = 0; c < 4; c++) begin
         if (c > 0) @(negedge clk);
         #1;
         chk("bp_ready", b8.in_ready, 0);
         chk("bp_valid", b8.out_valid, 1);
         chk("bp_hold", b8.data_out, 8'h44);
      end
      for (int c = 0; c < 20 && got < 4; c++) begin
         @(negedge clk);
         if (sent) b8.in_valid = 1'b0;
         b8.out_ready = 1'b1;
         #1;
         if (b8.in_valid && b8.in_ready) sent = 1'b1;
         if (b8.out_valid) begin
            chk("bp_drain", b8.data_out, e[got]);
            got++;
         end
      end
      chk("bp_count", got, 4);
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         b8.in_valid = 1'b0;
         #1 if (b8.out_valid) extra++;
      end
      chk("bp_extra", extra, 0);
   endtask

   task automatic reset_mid();
      int stale = 0;
      b8.out_ready = 1'b1;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         drive8(8'hF0 | 8'(c), 3'd0, 3'd0);
      end
      @(negedge clk);
      b8.in_valid = 1'b0;
      #1 chk("rm_inflight", b8.out_valid, 1);
      rst = 1'b1;
      @(negedge clk);
      chk("rm_valid", b8.out_valid, 0);
      chk("rm_data", b8.data_out, 0);
      chk("rm_zero", b8.out_zero, 0);
      chk("rm_ready", b8.in_ready, 1);
      rst = 1'b0;
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         #1 if (b8.out_valid) stale++;
      end
      chk("rm_stale", stale, 0);
   endtask

   task automatic rnd();
      logic [63:0] q8 [$], q32 [$];
      logic [63:0] e, last8 = '0, last32 = '0;
      logic stall8 = 1'b0, stall32 = 1'b0;
      int in8 = 0, in32 = 0, out8 = 0, out32 = 0;
      for (int c = 0; c < 20000 && (out8 < 1000 || out32 < 1000); c++) begin
         @(negedge clk);
         if (stall8) chk("rnd8_hold", b8.data_out, last8);
         if (stall32) chk("rnd32_hold", b32.data_out, last32);
         b8.in_valid = in8 < 1000 && $urandom_range(0, 3) != 0;
         b8.data_in = 8'($urandom);
         b8.shift_amt = 3'($urandom_range(0, 7));
         b8.mode = 3'($urandom_range(0, 7));
         b8.out_ready = $urandom_range(0, 3) != 0;
         b32.in_valid = in32 < 1000 && $urandom_range(0, 3) != 0;
         b32.data_in = $urandom;
         b32.shift_amt = 5'($urandom_range(0, 31));
         b32.mode = 3'($urandom_range(0, 7));
         b32.out_ready = $urandom_range(0, 3) != 0;
         #1;
         if (b8.in_valid && b8.in_ready) begin
            q8.push_back(ref_op(64'(b8.data_in), int'(b8.shift_amt), b8.mode, 8));
            in8++;
         end
         if (b32.in_valid && b32.in_ready) begin
            q32.push_back(ref_op(64'(b32.data_in), int'(b32.shift_amt), b32.mode, 32));
            in32++;
         end
         if (b8.out_valid && b8.out_ready) begin
            e = q8.size() > 0 ? q8.pop_front() : '1;
            chk("rnd8_data", b8.data_out, e);
            chk("rnd8_zero", b8.out_zero, e == 64'd0);
            out8++;
         end
         if (b32.out_valid && b32.out_ready) begin
            e = q32.size() > 0 ? q32.pop_front() : '1;
            chk("rnd32_data", b32.data_out, e);
            chk("rnd32_zero", b32.out_zero, e == 64'd0);
            out32++;
         end
         stall8 = b8.out_valid && !b8.out_ready;
         stall32 = b32.out_valid && !b32.out_ready;
         last8 = 64'(b8.data_out);
         last32 = 64'(b32.data_out);
      end
      chk("rnd8_beats", out8, 1000);
      chk("rnd8_left", q8.size(), 0);
      chk("rnd32_beats", out32, 1000);
      chk("rnd32_left", q32.size(), 0);
   endtask

   initial begin
      b8.in_valid = 1'b0; b8.data_in = '0; b8.shift_amt = '0; b8.mode = '0; b8.out_ready = 1'b1;
      b32.in_valid = 1'b0; b32.data_in = '0; b32.shift_amt = '0; b32.mode = '0; b32.out_ready = 1'b1;
      repeat (2) @(negedge clk);
      chk("rst_valid", b8.out_valid, 0);
      chk("rst_data", b8.data_out, 0);
      chk("rst_zero", b8.out_zero, 0);
      chk("rst_ready", b8.in_ready, 1);
      chk("rst32_valid", b32.out_valid, 0);
      rst = 1'b0;
      send1("sll", 8'hA3, 3'd3, 3'd0, 8'h18);
      send1("srl", 8'h80, 3'd7, 3'd1, 8'h01);
      send1("sra", 8'h90, 3'd2, 3'd2, 8'hE4);
      send1("rol", 8'hA5, 3'd4, 3'd3, 8'h5A);
      send1("ror", 8'h03, 3'd1, 3'd4, 8'h81);
      for (int i = 0; i < 6; i++) send1("amt0", 8'h6C, 3'd0, i == 5 ? 3'd7 : 3'(i), 8'h6C);
      send1("sll_max", 8'h01, 3'd7, 3'd0, 8'h80);
      send1("srl_zero", 8'h01, 3'd1, 3'd1, 8'h00);
      send1("sra_max", 8'h80, 3'd7, 3'd2, 8'hFF);
      send1("rol_max", 8'h80, 3'd7, 3'd3, 8'h40);
      send1("ror_max", 8'h01, 3'd7, 3'd4, 8'h02);
      send1("pass7", 8'h3C, 3'd5, 3'd7, 8'h3C);
      send1("pass5", 8'h96, 3'd3, 3'd5, 8'h96);
      stream5();
      backpressure();
      reset_mid();
      rnd();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
